// File: rtl/select_encode_reg.sv
// rtl/select_encode_reg.sv - registered IR field decoder producing one-hot register enables
module select_encode_reg #(
    parameter int NUM_REGS = 16,
    parameter int SEL_W    = $clog2(NUM_REGS),
    parameter int DATA_W   = 32,
    parameter int RA_LSB   = 23,
    parameter int RB_LSB   = 19,
    parameter int RC_LSB   = 15,
    parameter int IMM_W    = 19,
    parameter bit HOLD_SEL = 1'b1
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                IRin,
    input  logic [DATA_W-1:0]   bus_in,
    input  logic                Gra,
    input  logic                Grb,
    input  logic                Grc,
    input  logic                Rin,
    input  logic                Rout,
    input  logic                BAout,
    output logic [DATA_W-1:0]   ir,
    output logic [DATA_W-1:0]   C_sign_extended,
    output logic [NUM_REGS-1:0] reg_in,
    output logic [NUM_REGS-1:0] reg_out,
    output logic                zero_out,
    output logic [SEL_W-1:0]    sel_idx,
    output logic                sel_err
);

    logic [DATA_W-1:0]   r_ir;
    logic [NUM_REGS-1:0] r_reg_in;
    logic [NUM_REGS-1:0] r_reg_out;
    logic                r_zero_out;
    logic [SEL_W-1:0]    r_sel_idx;
    logic                r_sel_err;

    logic                w_any_gr;
    logic                w_multi_gr;
    logic                w_valid;
    logic [SEL_W-1:0]    w_idx;
    logic [NUM_REGS-1:0] w_reg_in_nxt;
    logic [NUM_REGS-1:0] w_reg_out_nxt;
    logic                w_zero_out_nxt;

    assign w_any_gr   = Gra | Grb | Grc;
    assign w_multi_gr = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
    assign w_valid    = w_any_gr | HOLD_SEL;

    // Fields come from the IR as it stands before this edge, so an IRin in
    // the same cycle does not affect the selection.
    always_comb begin
        w_idx = r_sel_idx;
        if (Gra)
            w_idx = r_ir[RA_LSB +: SEL_W];
        else if (Grb)
            w_idx = r_ir[RB_LSB +: SEL_W];
        else if (Grc)
            w_idx = r_ir[RC_LSB +: SEL_W];
    end

    // BAout on register 0 reads as a zero constant rather than the register.
    always_comb begin
        w_reg_in_nxt   = '0;
        w_reg_out_nxt  = '0;
        w_zero_out_nxt = 1'b0;
        if (w_valid) begin
            w_reg_in_nxt[w_idx] = Rin;
            if (w_idx == '0 && BAout && !Rout)
                w_zero_out_nxt = 1'b1;
            else
                w_reg_out_nxt[w_idx] = Rout | BAout;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_ir       <= '0;
            r_reg_in   <= '0;
            r_reg_out  <= '0;
            r_zero_out <= 1'b0;
            r_sel_idx  <= '0;
            r_sel_err  <= 1'b0;
        end else begin
            if (IRin)
                r_ir <= bus_in;
            r_reg_in   <= w_reg_in_nxt;
            r_reg_out  <= w_reg_out_nxt;
            r_zero_out <= w_zero_out_nxt;
            if (w_any_gr)
                r_sel_idx <= w_idx;
            if (w_multi_gr)
                r_sel_err <= 1'b1;
            else if (IRin)
                r_sel_err <= 1'b0;
        end
    end

    assign ir              = r_ir;
    assign C_sign_extended = {{(DATA_W-IMM_W){r_ir[IMM_W-1]}}, r_ir[IMM_W-1:0]};
    assign reg_in          = r_reg_in;
    assign reg_out         = r_reg_out;
    assign zero_out        = r_zero_out;
    assign sel_idx         = r_sel_idx;
    assign sel_err         = r_sel_err;

endmodule
